picorv32_mem_responder: RTL

- Responder end of the picorv32 native memory interface: mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb in; mem_ready/mem_rdata out.
- Backs the core with a word-addressed RAM that has byte strobes and a programmable response latency. An external stall input can stretch each access.
- Checks initiator protocol and counts completed transfers.
- Used in simulation and formal harnesses in place of a free mem_ready/mem_rdata environment.

---
 rtl/picorv32_mem_pkg.sv | 19 +
 rtl/picorv32_mem_ram.sv | 28 ++
 rtl/picorv32_mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/picorv32_mem_pkg.sv
// rtl/picorv32_mem_pkg.sv - shared types and constants for the picorv32 memory responder
// Contents: responder state enum, latency counter width, transfer counter
// saturation value, default out-of-range read word, saturating increment helper.
package picorv32_mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int          CNT_W            = 4;
    localparam logic [15:0] CNT_MAX          = 16'hFFFF;
    localparam logic [31:0] OOB_WORD_DEFAULT = 32'h0000_0000;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/picorv32_mem_ram.sv
// rtl/picorv32_mem_ram.sv - single-port word RAM with byte write enables
// Ports: clk; we[3:0] byte write enables; addr word address; wdata write word;
// rdata combinational read of the addressed word. Contents are never reset.
module picorv32_mem_ram
    import picorv32_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem_q [0:(2**ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/picorv32_mem_responder.sv
// rtl/picorv32_mem_responder.sv - picorv32 native memory responder with latency, stall and protocol checks
// Ports: clk, reset (sync, active-high); mem_valid/mem_instr/mem_addr/mem_wdata/
// mem_wstrb request from the core; mem_ready/mem_rdata registered response;
// stall_in holds the latency counter; oob pulses with an out-of-range completion;
// protocol_err sticky initiator violation; txn_count/fetch_count saturating
// completed-transfer counters.
module picorv32_mem_responder
    import picorv32_mem_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] OOB_WORD  = OOB_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        stall_in,
    output logic        oob,
    output logic        protocol_err,
    output logic [15:0] txn_count,
    output logic [15:0] fetch_count
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               instr_q, instr_d;
    logic               mem_ready_q, mem_ready_d;
    logic [31:0]        mem_rdata_q, mem_rdata_d;
    logic               oob_q, oob_d;
    logic               protocol_err_q, protocol_err_d;
    logic [15:0]        txn_count_q, txn_count_d;
    logic [15:0]        fetch_count_q, fetch_count_d;

    logic [3:0]         ram_we;
    logic [31:0]        ram_rdata;
    logic               addr_oob;

    // Any address bit above the RAM's byte range makes the access out of range.
    assign addr_oob = |addr_q[31:ADDR_BITS+2];

    picorv32_mem_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q[ADDR_BITS+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        instr_d        = instr_q;
        mem_ready_d    = 1'b0;
        mem_rdata_d    = 32'h0;
        oob_d          = 1'b0;
        protocol_err_d = protocol_err_q;
        txn_count_d    = txn_count_q;
        fetch_count_d  = fetch_count_q;
        ram_we         = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                // A request still high during the ack cycle is the one just
                // served; the next request is taken one cycle later.
                if (mem_valid && !mem_ready_q) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = ST_WAIT;
                    if (mem_addr[1:0] != 2'b00) begin
                        protocol_err_d = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (!mem_valid) begin
                    // Initiator withdrew the request: abort, no write, no ready.
                    protocol_err_d = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    if ((mem_addr != addr_q) || (mem_wdata != wdata_q) ||
                        (mem_wstrb != wstrb_q)) begin
                        protocol_err_d = 1'b1;
                    end
                    if (!stall_in) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            mem_ready_d = 1'b1;
                            oob_d       = addr_oob;
                            if (wstrb_q == 4'b0000) begin
                                mem_rdata_d = addr_oob ? OOB_WORD : ram_rdata;
                            end else if (!addr_oob) begin
                                ram_we = wstrb_q;
                            end
                            txn_count_d = sat_inc(txn_count_q);
                            if (instr_q) begin
                                fetch_count_d = sat_inc(fetch_count_q);
                            end
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Reset drops an in-flight access, including its write.
        if (reset) begin
            ram_we = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            wstrb_q        <= 4'b0000;
            instr_q        <= 1'b0;
            mem_ready_q    <= 1'b0;
            mem_rdata_q    <= 32'h0;
            oob_q          <= 1'b0;
            protocol_err_q <= 1'b0;
            txn_count_q    <= 16'h0;
            fetch_count_q  <= 16'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            instr_q        <= instr_d;
            mem_ready_q    <= mem_ready_d;
            mem_rdata_q    <= mem_rdata_d;
            oob_q          <= oob_d;
            protocol_err_q <= protocol_err_d;
            txn_count_q    <= txn_count_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign mem_ready    = mem_ready_q;
    assign mem_rdata    = mem_rdata_q;
    assign oob          = oob_q;
    assign protocol_err = protocol_err_q;
    assign txn_count    = txn_count_q;
    assign fetch_count  = fetch_count_q;

endmodule
